fu_mult_sched: RTL

//  Shares one pipelined multiplier (mult, NUM_STAGE stages) among NUM_REQ issue requesters.
//  Per cycle: round-robin grant, derive sign controls from the opcode, and carry tag/op alongside the datapath.

---
 rtl/fu_mult_sched.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/fu_mult_sched.sv
// Shared pipelined-multiplier scheduler: round-robin issue, tag pipe and credit-protected completion queue.
// Optional same-cycle completion bypass enabled by defining MULT_SCHED_BYPASS_EN.
module fu_mult_sched #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_STAGE = 4,
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned CQ_DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [XLEN*NUM_REQ-1:0]    req_r1,
  input  logic [XLEN*NUM_REQ-1:0]    req_r2,
  input  logic [TAG_W*NUM_REQ-1:0]   req_tag,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       mult_start,
  output logic [1:0]                 mult_sign,
  output logic [XLEN-1:0]            mult_mcand,
  output logic [XLEN-1:0]            mult_mplier,
  input  logic                       mult_done,
  input  logic [2*XLEN-1:0]          mult_product,
  input  logic                       complete_stall,
  output logic                       cmp_valid,
  output logic [XLEN-1:0]            cmp_value,
  output logic [TAG_W-1:0]           cmp_tag
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W  = IDX_W + 1;
  localparam int unsigned CQ_AW  = (CQ_DEPTH > 1) ? $clog2(CQ_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(CQ_DEPTH + 1);
  localparam int unsigned INF_W  = $clog2(NUM_STAGE + 1);
  localparam int unsigned CRED_W = $clog2(NUM_STAGE + CQ_DEPTH + 1);

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;
  localparam logic [1:0] OP_MULHU  = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } tp_t;

  typedef struct packed {
    logic [XLEN-1:0]  value;
    logic [TAG_W-1:0] tag;
  } cq_t;

  logic [IDX_W-1:0] rr_q, rr_d;
  tp_t              tp_q [NUM_STAGE];
  tp_t              tp_d [NUM_STAGE];
  cq_t              cq_mem_q [CQ_DEPTH];
  cq_t              cq_mem_d [CQ_DEPTH];
  logic [CQ_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CQ_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cq_cnt_q, cq_cnt_d;

  logic [INF_W-1:0] inflight;
  logic             issue_ok;
  logic             gnt_found;
  logic [IDX_W-1:0] gnt_idx;
  logic [SUM_W-1:0] cand_sum;
  logic [IDX_W-1:0] cand;
  logic [1:0]       sel_op;
  logic [TAG_W-1:0] sel_tag;
  logic [XLEN-1:0]  sel_r1;
  logic [XLEN-1:0]  sel_r2;
  tp_t              tail;
  logic [XLEN-1:0]  res_value;
  logic             bypass;
  logic             push;
  logic             pop;

  // Credit: every op in the pipe or the queue holds one queue slot
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < NUM_STAGE; i++) begin
      inflight = inflight + INF_W'(tp_q[i].valid);
    end
    issue_ok = (CRED_W'(inflight) + CRED_W'(cq_cnt_q)) < CRED_W'(CQ_DEPTH);
  end

  // Round-robin arbiter and operand mux
  always_comb begin
    grant     = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    sel_op    = '0;
    sel_tag   = '0;
    sel_r1    = '0;
    sel_r2    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_q} + SUM_W'(k);
      if (cand_sum >= SUM_W'(NUM_REQ)) begin
        cand_sum = cand_sum - SUM_W'(NUM_REQ);
      end
      cand = cand_sum[IDX_W-1:0];
      if (issue_ok && !reset && !gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_found && (gnt_idx == IDX_W'(i))) begin
        grant[i] = 1'b1;
        sel_op   = req_op[2*i +: 2];
        sel_tag  = req_tag[TAG_W*i +: TAG_W];
        sel_r1   = req_r1[XLEN*i +: XLEN];
        sel_r2   = req_r2[XLEN*i +: XLEN];
      end
    end
  end

  // Issue side: start, sign controls, operands
  always_comb begin
    mult_start  = gnt_found;
    mult_mcand  = sel_r1;
    mult_mplier = sel_r2;
    mult_sign   = 2'b00;
    if (gnt_found) begin
      case (sel_op)
        OP_MUL, OP_MULH: mult_sign = 2'b11;
        OP_MULHSU:       mult_sign = 2'b01;
        OP_MULHU:        mult_sign = 2'b00;
        default:         mult_sign = 2'b00;
      endcase
    end
  end

  // Pointer advance and tag pipe shift
  always_comb begin
    rr_d = rr_q;
    if (gnt_found) begin
      rr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
    tp_d[0] = '{valid: gnt_found, op: sel_op, tag: sel_tag};
    for (int unsigned i = 1; i < NUM_STAGE; i++) begin
      tp_d[i] = tp_q[i-1];
    end
  end

  assign tail      = tp_q[NUM_STAGE-1];
  assign res_value = (tail.op == OP_MUL) ? mult_product[XLEN-1:0] : mult_product[2*XLEN-1:XLEN];

  // Completion queue
  always_comb begin
    bypass = 1'b0;
`ifdef MULT_SCHED_BYPASS_EN
    bypass = (cq_cnt_q == '0) && !complete_stall && tail.valid;
`endif
    push     = tail.valid && !bypass;
    pop      = (cq_cnt_q != '0) && !complete_stall;
    cq_mem_d = cq_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cq_cnt_d = cq_cnt_q;
    if (push) begin
      cq_mem_d[wr_ptr_q] = '{value: res_value, tag: tail.tag};
      wr_ptr_d = (CQ_DEPTH == 1) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (CQ_DEPTH == 1) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cq_cnt_d = cq_cnt_q + 1'b1;
      2'b01:   cq_cnt_d = cq_cnt_q - 1'b1;
      default: cq_cnt_d = cq_cnt_q;
    endcase
  end

  // Head of queue drives the complete stage (or the bypassed product)
  always_comb begin
    cmp_valid = (cq_cnt_q != '0) || bypass;
    cmp_value = bypass ? res_value : cq_mem_q[rd_ptr_q].value;
    cmp_tag   = bypass ? tail.tag  : cq_mem_q[rd_ptr_q].tag;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q     <= '0;
      tp_q     <= '{default: '0};
      cq_mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cq_cnt_q <= '0;
    end else begin
      rr_q     <= rr_d;
      tp_q     <= tp_d;
      cq_mem_q <= cq_mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cq_cnt_q <= cq_cnt_d;
    end
  end

  a_done_matches_pipe: assert property (@(posedge clock) disable iff (reset)
    mult_done == tail.valid);

  a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
    !(push && (cq_cnt_q == CNT_W'(CQ_DEPTH))));

endmodule
